// File: rtl/amp_seq_if.sv
// amp_seq_if: request, status and amplifier pin bundle for amp_seq.
// master = system/amp side, slave = the sequencer.
interface amp_seq_if;
  logic       amp_on;
  logic       mute_req;
  logic       wr_req;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       ready;
  logic       wr_done;
  logic       wr_nack;
  logic [2:0] state;
  logic       amp_i2c_scl;
  logic       amp_i2c_sdai;
  logic       amp_i2c_sdao;
  logic       amp_nenable;
  logic       amp_mute;

  modport master (
    output amp_on, mute_req, wr_req, wr_reg, wr_data,
    output amp_i2c_sdai,
    input  ready, wr_done, wr_nack, state,
    input  amp_i2c_scl, amp_i2c_sdao,
    input  amp_nenable, amp_mute
  );

  modport slave (
    input  amp_on, mute_req, wr_req, wr_reg, wr_data,
    input  amp_i2c_sdai,
    output ready, wr_done, wr_nack, state,
    output amp_i2c_scl, amp_i2c_sdao,
    output amp_nenable, amp_mute
  );
endinterface

// File: rtl/amp_seq.sv
// amp_seq: class-D amplifier power/mute sequencer with a
// write-only I2C master doing 3-byte register writes.
module amp_seq #(
  parameter int          CLK_DIV  = 30,
  parameter int          T_EN     = 1024,
  parameter int          T_OFF    = 256,
  parameter logic [6:0]  DEV_ADDR = 7'h2C
) (
  input  logic      clk,
  input  logic      resetb,
  amp_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWRUP  = 3'd1,
    S_ACTIVE = 3'd2,
    S_XFER   = 3'd3,
    S_PWRDN  = 3'd4
  } st_t;

  typedef enum logic [1:0] {
    P_START,
    P_BIT,
    P_STOP
  } ph_t;

  localparam int TMAX = (T_EN > T_OFF) ? T_EN : T_OFF;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(CLK_DIV);

  localparam logic [CW-1:0] EN_LAST  = CW'(T_EN - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0]    ADDR_B   = {DEV_ADDR, 1'b0};

  st_t           st, st_n;
  ph_t           ph, ph_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] div, div_n;
  logic [1:0]    q, q_n;
  logic [3:0]    bitn, bitn_n;
  logic [1:0]    byten, byten_n;
  logic [7:0]    reg_q, reg_n;
  logic [7:0]    dat_q, dat_n;
  logic          nack, nack_n;
  logic          scl, scl_n;
  logic          sda, sda_n;
  logic          nen, nen_n;
  logic          mute, mute_n;
  logic          rdy, rdy_n;
  logic          done, done_n;
  logic          wnack, wnack_n;

  logic [7:0]    cur_b;
  logic [7:0]    nxt_b;
  logic [2:0]    bi;
  logic          tick;

  assign cur_b = (byten == 2'd0) ? ADDR_B :
                 (byten == 2'd1) ? reg_q : dat_q;
  assign nxt_b = (byten == 2'd0) ? reg_q : dat_q;
  assign bi    = 3'd6 - bitn[2:0];
  assign tick  = (div == DIV_LAST);

  // State and output registers; reset releases the bus at once.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      st    <= S_OFF;
      ph    <= P_START;
      cnt   <= '0;
      div   <= '0;
      q     <= '0;
      bitn  <= '0;
      byten <= '0;
      reg_q <= '0;
      dat_q <= '0;
      nack  <= 1'b0;
      scl   <= 1'b1;
      sda   <= 1'b1;
      nen   <= 1'b1;
      mute  <= 1'b1;
      rdy   <= 1'b0;
      done  <= 1'b0;
      wnack <= 1'b0;
    end else begin
      st    <= st_n;
      ph    <= ph_n;
      cnt   <= cnt_n;
      div   <= div_n;
      q     <= q_n;
      bitn  <= bitn_n;
      byten <= byten_n;
      reg_q <= reg_n;
      dat_q <= dat_n;
      nack  <= nack_n;
      scl   <= scl_n;
      sda   <= sda_n;
      nen   <= nen_n;
      mute  <= mute_n;
      rdy   <= rdy_n;
      done  <= done_n;
      wnack <= wnack_n;
    end
  end

  // Next state: power sequencing plus quarter-bit I2C engine.
  always_comb begin
    st_n    = st;
    ph_n    = ph;
    cnt_n   = cnt;
    div_n   = div;
    q_n     = q;
    bitn_n  = bitn;
    byten_n = byten;
    reg_n   = reg_q;
    dat_n   = dat_q;
    nack_n  = nack;
    scl_n   = scl;
    sda_n   = sda;
    nen_n   = nen;
    wnack_n = wnack;
    done_n  = 1'b0;

    case (st)
      S_OFF: begin
        if (bus.amp_on) begin
          st_n  = S_PWRUP;
          cnt_n = '0;
          nen_n = 1'b0;
        end
      end

      S_PWRUP: begin
        if (!bus.amp_on) begin
          st_n  = S_PWRDN;
          cnt_n = '0;
        end else if (cnt == EN_LAST) begin
          st_n = S_ACTIVE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_ACTIVE: begin
        if (!bus.amp_on) begin
          st_n  = S_PWRDN;
          cnt_n = '0;
        end else if (bus.wr_req) begin
          st_n    = S_XFER;
          reg_n   = bus.wr_reg;
          dat_n   = bus.wr_data;
          ph_n    = P_START;
          div_n   = '0;
          q_n     = 2'd0;
          bitn_n  = 4'd0;
          byten_n = 2'd0;
          nack_n  = 1'b0;
          scl_n   = 1'b1;
          sda_n   = 1'b0;
        end
      end

      S_XFER: begin
        if (!tick) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          case (ph)
            P_START: begin
              if (q == 2'd0) begin
                q_n   = 2'd1;
                scl_n = 1'b0;
              end else begin
                ph_n  = P_BIT;
                q_n   = 2'd0;
                sda_n = cur_b[7];
              end
            end

            P_BIT: begin
              case (q)
                2'd0: q_n = 2'd1;
                2'd1: begin
                  q_n   = 2'd2;
                  scl_n = 1'b1;
                end
                2'd2: begin
                  q_n = 2'd3;
                  if (bitn == 4'd8 && bus.amp_i2c_sdai)
                    nack_n = 1'b1;
                end
                default: begin
                  q_n   = 2'd0;
                  scl_n = 1'b0;
                  if (bitn == 4'd8) begin
                    if (nack || byten == 2'd2) begin
                      ph_n  = P_STOP;
                      sda_n = 1'b0;
                    end else begin
                      byten_n = byten + 1'b1;
                      bitn_n  = 4'd0;
                      sda_n   = nxt_b[7];
                    end
                  end else begin
                    bitn_n = bitn + 1'b1;
                    sda_n  = (bitn == 4'd7) ? 1'b1
                                            : cur_b[bi];
                  end
                end
              endcase
            end

            P_STOP: begin
              if (q == 2'd0) begin
                q_n   = 2'd1;
                scl_n = 1'b1;
              end else if (q == 2'd1) begin
                q_n   = 2'd2;
                sda_n = 1'b1;
              end else begin
                st_n    = bus.amp_on ? S_ACTIVE : S_PWRDN;
                cnt_n   = '0;
                done_n  = 1'b1;
                wnack_n = nack;
                scl_n   = 1'b1;
                sda_n   = 1'b1;
              end
            end

            default: ph_n = P_START;
          endcase
        end
      end

      S_PWRDN: begin
        if (cnt == OFF_LAST) begin
          st_n  = S_OFF;
          nen_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: st_n = S_OFF;
    endcase

    mute_n = !((st_n == S_ACTIVE || st_n == S_XFER)
               && !bus.mute_req);
    rdy_n  = (st_n == S_ACTIVE) && bus.amp_on;
  end

  assign bus.state        = st;
  assign bus.ready        = rdy;
  assign bus.wr_done      = done;
  assign bus.wr_nack      = wnack;
  assign bus.amp_i2c_scl  = scl;
  assign bus.amp_i2c_sdao = sda;
  assign bus.amp_nenable  = nen;
  assign bus.amp_mute     = mute;

endmodule

// File: tb/tb_amp_seq.sv
// tb_amp_seq: scoreboard bench for amp_seq with an I2C slave
// model decoding the bus and a transaction-level reference.
module tb_amp_seq;

  localparam int CD   = 4;
  localparam int TEN  = 16;
  localparam int TOFF = 32;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  amp_seq_if bus ();

  amp_seq #(
    .CLK_DIV  (CD),
    .T_EN     (TEN),
    .T_OFF    (TOFF),
    .DEV_ADDR (7'h2C)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  logic slv_drv = 1'b1;
  assign bus.amp_i2c_sdai = bus.amp_i2c_sdao & slv_drv;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int          t0;
    int          n;
    int          quarters;
    logic        nk;
    logic [23:0] bytes;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cap[$];
  int         nack_at = 3;
  int         bp = 0;
  int         starts = 0;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  logic [7:0] sh = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h",
                  nm, act, req);
  endtask

  // Reference: the slave NACKs byte index na (na>2: ACK all).
  function automatic exp_t model(input int t0,
                                 input logic [7:0] r,
                                 input logic [7:0] d,
                                 input int na);
    exp_t e;
    e.t0       = t0;
    e.n        = (na > 2) ? 3 : na + 1;
    e.nk       = (na <= 2);
    e.quarters = 2 + 9 * 4 * e.n + 3;
    e.bytes    = {8'h58, r, d};
    return e;
  endfunction

  // I2C slave: decode START/STOP/bits, drive ACK.
  always @(negedge clk) begin
    logic s;
    logic d;
    s = bus.amp_i2c_scl;
    d = bus.amp_i2c_sdai;
    if (!resetb) begin
      bp = 0;
      slv_drv = 1'b1;
    end else if (pscl && s && psda && !d) begin
      starts++;
      bp = 0;
      cap.delete();
    end else if (!pscl && s) begin
      if (bp < 8) begin
        sh = {sh[6:0], d};
        if (bp == 7) cap.push_back(sh);
      end
      bp = (bp == 8) ? 0 : bp + 1;
    end else if (pscl && !s) begin
      slv_drv = !(bp == 8 &&
                  (int'(cap.size()) - 1) != nack_at);
    end
    pscl = s;
    psda = d;
  end

  // Scoreboard monitor: compare each completed write.
  always @(negedge clk) begin
    if (resetb && bus.wr_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        logic [7:0] got;
        e = sb.pop_front();
        chk("latency", cyc - e.t0, e.quarters * CD);
        chk("wr_nack", {31'd0, bus.wr_nack}, {31'd0, e.nk});
        chk("nbytes", cap.size(), e.n);
        for (int i = 0; i < e.n; i++) begin
          got = (i < cap.size()) ? cap[i] : 8'hxx;
          chk("byte", {24'd0, got},
              {24'd0, e.bytes[23 - 8 * i -: 8]});
        end
      end
    end
  end

  task automatic issue(input logic [7:0] r,
                       input logic [7:0] d,
                       input int na,
                       input logic m,
                       input logic acc);
    @(negedge clk);
    nack_at      = na;
    bus.mute_req = m;
    bus.wr_req   = 1'b1;
    bus.wr_reg   = r;
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    if (acc) begin
      sb.push_back(model(cyc, r, d, na));
      chk("xfer_state", bus.state, 3);
      chk("mute_xfer", bus.amp_mute, m);
    end else begin
      chk("ignored", bus.state == 3'd3, 0);
    end
  endtask

  task automatic wait_sb;
    int k;
    k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (bus.state !== s && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("state_timeout", 0, 1);
  endtask

  initial begin
    int s0;
    int k;
    bus.amp_on   = 1'b0;
    bus.mute_req = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_reg   = 8'h00;
    bus.wr_data  = 8'h00;

    #12;
    chk("rst_state", bus.state, 0);
    chk("rst_nen", bus.amp_nenable, 1);
    chk("rst_mute", bus.amp_mute, 1);
    chk("rst_scl", bus.amp_i2c_scl, 1);
    chk("rst_sda", bus.amp_i2c_sdao, 1);
    chk("rst_ready", bus.ready, 0);
    chk("rst_done", bus.wr_done, 0);
    chk("rst_nack", bus.wr_nack, 0);

    @(negedge clk);
    resetb = 1'b1;
    bus.amp_on = 1'b1;
    @(posedge clk);
    #1;
    chk("pwrup_nen", bus.amp_nenable, 0);
    chk("pwrup_state", bus.state, 1);
    repeat (TEN - 1) @(posedge clk);
    #1;
    chk("pwrup_hold", bus.state, 1);
    chk("pwrup_mute", bus.amp_mute, 1);
    @(posedge clk);
    #1;
    chk("active_state", bus.state, 2);
    chk("active_mute", bus.amp_mute, 0);
    chk("active_ready", bus.ready, 1);

    @(negedge clk);
    bus.mute_req = 1'b1;
    @(posedge clk);
    #1;
    chk("mute_on", bus.amp_mute, 1);
    @(negedge clk);
    bus.mute_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mute_off", bus.amp_mute, 0);

    issue(8'h05, 8'hA3, 3, 1'b0, 1'b1);
    wait_sb();
    issue(8'h05, 8'hA3, 0, 1'b0, 1'b1);
    wait_sb();
    issue(8'h05, 8'hA3, 1, 1'b0, 1'b1);
    wait_sb();
    @(negedge clk);
    chk("ready_back", bus.ready, 1);
    chk("bus_idle", {bus.amp_i2c_scl, bus.amp_i2c_sdao}, 2'b11);

    for (int i = 0; i < 8; i++) begin
      issue(8'($urandom), 8'($urandom),
            int'($urandom_range(0, 3)),
            1'($urandom), 1'b1);
      wait_sb();
    end

    issue(8'h11, 8'h22, 3, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    bus.amp_on = 1'b0;
    k = 0;
    while (!bus.wr_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("drop_timeout", 0, 1);
    chk("drop_state", bus.state, 4);
    chk("drop_mute", bus.amp_mute, 1);
    chk("drop_ready", bus.ready, 0);
    repeat (TOFF - 1) @(posedge clk);
    #1;
    chk("pwrdn_hold", bus.state, 4);
    chk("pwrdn_nen", bus.amp_nenable, 0);
    @(posedge clk);
    #1;
    chk("off_state", bus.state, 0);
    chk("off_nen", bus.amp_nenable, 1);

    s0 = starts;
    @(negedge clk);
    bus.amp_on = 1'b1;
    @(posedge clk);
    #1;
    chk("repwr_state", bus.state, 1);
    issue(8'h77, 8'h88, 3, 1'b0, 1'b0);
    issue(8'h99, 8'h44, 3, 1'b0, 1'b0);
    wait_state(3'd2);
    chk("pwrup_ign_bus", starts, s0);
    chk("ready_again", bus.ready, 1);

    @(negedge clk);
    bus.amp_on  = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_reg  = 8'h12;
    bus.wr_data = 8'h34;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    chk("race_state", bus.state, 4);
    chk("race_ready", bus.ready, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.amp_on = 1'b1;
    repeat (TOFF - 6) @(posedge clk);
    #1;
    chk("noshort_hold", bus.state, 4);
    @(posedge clk);
    #1;
    chk("noshort_off", bus.state, 0);
    chk("noshort_nen", bus.amp_nenable, 1);
    @(posedge clk);
    #1;
    chk("reenter_pwrup", bus.state, 1);
    chk("race_bus", starts, s0);

    wait_state(3'd2);
    issue(8'h3C, 8'h5A, 3, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    resetb = 1'b0;
    #1;
    chk("arst_scl", bus.amp_i2c_scl, 1);
    chk("arst_sda", bus.amp_i2c_sdao, 1);
    chk("arst_nen", bus.amp_nenable, 1);
    chk("arst_mute", bus.amp_mute, 1);
    chk("arst_state", bus.state, 0);
    sb.delete();
    bus.amp_on = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_state", bus.state, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/amp_seq.md
# amp_seq

Power-up/mute sequencer and write-only I2C master for the external class-D amplifier. Sits beside the register bank in the top level: takes the amplifier enable/mute request bits and register-write requests from the system configuration, drives amp_nenable/amp_mute with fixed settle delays, and performs 3-byte register writes on the amp_i2c pins. Write requests are accepted only while the amplifier is powered and settled.

## Interface
- CLK_DIV, 30: clk cycles per I2C quarter-bit (must be ≥2)
- T_EN, 1024: clk cycles from amp_nenable falling to ACTIVE
- T_OFF, 256: clk cycles from amp_mute rising to amp_nenable rising
- DEV_ADDR, 7'h2C: 7-bit amplifier I2C address

- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- amp_on  in  1  level request: amplifier powered
- mute_req  in  1  level request: amplifier muted
- wr_req  in  1  single-cycle write request, valid only when ready=1
- wr_reg  in  8  register address, sampled with wr_req
- wr_data  in  8  register data, sampled with wr_req
- ready  out  1  high in ACTIVE with amp_on=1
- wr_done  out  1  one-cycle pulse at transfer end
- wr_nack  out  1  valid with wr_done: 1 = any byte NACKed
- state  out  3  OFF=0, PWRUP=1, ACTIVE=2, XFER=3, PWRDN=4
- amp_i2c_scl  out  1  SCL, 1 = released
- amp_i2c_sdai  in  1  SDA input
- amp_i2c_sdao  out  1  SDA open-drain drive, 0 = pull low, 1 = released
- amp_nenable  out  1  amplifier enable, active low
- amp_mute  out  1  amplifier mute, active high

## Operation
- Reset values: state=OFF, amp_nenable=1, amp_mute=1, amp_i2c_scl=1, amp_i2c_sdao=1, ready=0, wr_done=0, wr_nack=0. Reset mid-transfer releases bus immediately; no stop generated.
- OFF: amp_on=1 → PWRUP, amp_nenable=0.
- PWRUP: counts T_EN cycles → ACTIVE. amp_on=0 → PWRDN.
- ACTIVE: amp_on=0 → PWRDN (wins over simultaneous wr_req). wr_req=1 → latch wr_reg/wr_data, XFER.
- XFER: runs full transfer; amp_on falling does not abort; at end → ACTIVE if amp_on=1, else PWRDN.
- PWRDN: amp_mute=1 on entry; counts T_OFF cycles → OFF, amp_nenable=1. amp_on reasserting does not shorten PWRDN; OFF then re-enters PWRUP next cycle.
- amp_mute = 1 unless state∈{ACTIVE,XFER} and mute_req=0.
- wr_req while ready=0: ignored, no wr_done.
- Transfer: START, byte {DEV_ADDR,0}, ACK, wr_reg, ACK, wr_data, ACK, STOP. Bytes MSB first. During ACK bit sdao=1; sdai sampled at end of quarter Q2 (mid-SCL-high); sdai=1 = NACK → skip remaining bytes, go to STOP, wr_nack=1.
- No clock-stretching, no arbitration; SCL is output-only.

## Timing
- All outputs registered; change on the same edge as the state transition causing them.
- amp_nenable falls on the edge sampling amp_on=1 in OFF; ACTIVE entered T_EN cycles later; amp_mute falls then if mute_req=0.
- mute_req change visible on amp_mute one cycle later (in ACTIVE/XFER).
- Quarter = CLK_DIV cycles. START: 2 quarters (SCL=1 SDA=0, then SCL=0). Each bit: 4 quarters, Q0–Q1 SCL=0 (SDA updated at Q0 start), Q2–Q3 SCL=1. STOP: 3 quarters (SCL=0 SDA=0; SCL=1 SDA=0; SCL=1 SDA=1).
- Full write: 2+27×4+3 = 113 quarters; NACK on address: 2+9×4+3 = 41 quarters; NACK on reg byte: 2+18×4+3 = 77 quarters.
- wr_done pulses on the cycle after the last STOP quarter, same edge as XFER exit; ready returns to 1 on that edge if amp_on=1.
- Quarter counter restarts at transfer start; no partial quarter at beginning.

## Test plan
- Reset, amp_on=1, mute_req=0, CLK_DIV=4, T_EN=16 → amp_nenable=0 at edge 1, state=ACTIVE and amp_mute=0 16 cycles later, ready=1.
- Write wr_reg=8'h05, wr_data=8'hA3, slave ACKs all → SDA bytes 8'h58, 8'h05, 8'hA3; wr_done after 113×4=452 cycles, wr_nack=0.
- Same write, no slave (sdai=1) → STOP after 41 quarters (164 cycles), wr_done with wr_nack=1.
- Drop amp_on mid-XFER → transfer completes with STOP, then PWRDN: amp_mute=1, amp_nenable=1 T_OFF cycles later, state=OFF.
- wr_req during PWRUP and on same cycle amp_on falls in ACTIVE → ignored, no wr_done, no bus activity.
- Assert resetb=0 mid-byte → SCL=1, SDA=1, amp_nenable=1, amp_mute=1 immediately, without clock edge.
